// File: rtl/mult_pkg.sv
// Shared types for the add-shift multiplier control path: FSM state encoding
// and the default operand width.
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADD,
        SHIFT,
        DONE
    } mult_state_t;

    localparam int MULT_WIDTH = 8;

endpackage

// File: rtl/mult_control.sv
// Control FSM for the signed add-shift multiplier: one clear, then WIDTH
// add/shift iterations, the last of which subtracts the multiplicand.
module mult_control
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Run,
    input  logic                     ClearA_LoadB,
    input  logic                     M,
    output logic                     Clr_A,
    output logic                     Ld_A,
    output logic                     Ld_B,
    output logic                     Shift_En,
    output logic                     Add,
    output logic                     Sub,
    output logic                     Busy,
    output logic                     Done,
    output logic [$clog2(WIDTH)-1:0] Step
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mult_state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             last_iter;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign last_iter = (cnt == LAST);
    assign Step      = cnt;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        Clr_A      = 1'b0;
        Ld_A       = 1'b0;
        Ld_B       = 1'b0;
        Shift_En   = 1'b0;
        Add        = 1'b0;
        Sub        = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                // A start request wins over a pending load of B.
                if (Run) begin
                    state_next = START;
                end else if (ClearA_LoadB) begin
                    Ld_B  = 1'b1;
                    Clr_A = 1'b1;
                end
            end
            START: begin
                Busy       = 1'b1;
                Clr_A      = 1'b1;
                cnt_next   = '0;
                state_next = ADD;
            end
            ADD: begin
                Busy = 1'b1;
                // The multiplier MSB carries negative weight, so the final
                // partial product is subtracted instead of added.
                if (M) begin
                    Ld_A = 1'b1;
                    if (last_iter) begin
                        Sub = 1'b1;
                    end else begin
                        Add = 1'b1;
                    end
                end
                state_next = SHIFT;
            end
            SHIFT: begin
                Busy     = 1'b1;
                Shift_En = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end else begin
                    cnt_next   = cnt + CNT_W'(1);
                    state_next = ADD;
                end
            end
            DONE: begin
                Done = 1'b1;
                // Holding Run keeps us here so one press yields one multiply.
                if (!Run) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_control.sv
// Randomized scoreboard bench for mult_control: a cycle-offset reference model
// predicts every output each cycle; a negedge monitor pops and compares.
module tb_mult_control;
    import mult_pkg::*;

    localparam int W     = MULT_WIDTH;
    localparam int SW    = $clog2(W);
    localparam int KDONE = 2 * W + 2;

    typedef logic [8+SW-1:0] obs_t;

    logic          Clk = 1'b0;
    logic          Reset, Run, ClearA_LoadB, M;
    logic          Clr_A, Ld_A, Ld_B, Shift_En, Add, Sub, Busy, Done;
    logic [SW-1:0] Step;

    mult_control #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
        .Clr_A(Clr_A), .Ld_A(Ld_A), .Ld_B(Ld_B), .Shift_En(Shift_En),
        .Add(Add), .Sub(Sub), .Busy(Busy), .Done(Done), .Step(Step)
    );

    always #5 Clk = ~Clk;

    obs_t         exp_q[$];
    int           vectors     = 0;
    int           miscompares = 0;
    int           k           = 0;  // cycles since Run accepted: 0 idle, KDONE done
    logic [W-1:0] mb          = '0; // multiplier value held in the B register
    int           sh_cnt      = 0;
    int           lda_cnt     = 0;
    logic         done_d      = 1'b0;
    obs_t         act_o, exp_o;

    // Expected outputs for one cycle, from the cycle offset of the multiply.
    function automatic obs_t model_out(int kk, logic run, logic clb, logic m);
        logic clr, lda, ldb, sh, add, sub, busy, done;
        logic [SW-1:0] st;
        int i;
        {clr, lda, ldb, sh, add, sub, busy, done} = '0;
        st = '0;
        if (kk == 0) begin
            if (!run && clb) begin
                ldb = 1'b1;
                clr = 1'b1;
            end
        end else if (kk == 1) begin
            busy = 1'b1;
            clr  = 1'b1;
        end else if (kk < KDONE) begin
            busy = 1'b1;
            i    = (kk - 2) / 2;
            st   = SW'(i);
            if (kk % 2 == 0) begin
                if (m) begin
                    lda = 1'b1;
                    if (i == W - 1) sub = 1'b1;
                    else            add = 1'b1;
                end
            end else begin
                sh = 1'b1;
            end
        end else begin
            done = 1'b1;
            st   = SW'(W - 1);
        end
        return {clr, lda, ldb, sh, add, sub, busy, done, st};
    endfunction

    task automatic cycle(input logic run, input logic clb, input logic rst);
        logic m;
        if (k >= 2 && k < KDONE && (k % 2 == 0)) m = mb[(k-2)/2];
        else                                      m = 1'($urandom);
        Run          = run;
        ClearA_LoadB = clb;
        Reset        = rst;
        M            = m;
        exp_q.push_back(model_out(k, run, clb, m));
        @(posedge Clk);
        if (rst)             k = 0;
        else if (k == 0)     k = run ? 1 : 0;
        else if (k < KDONE)  k = k + 1;
        else if (!run)       k = 0;
        #1;
    endtask

    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_o = exp_q.pop_front();
            act_o = {Clr_A, Ld_A, Ld_B, Shift_En, Add, Sub, Busy, Done, Step};
            vectors++;
            if (act_o !== exp_o) begin
                miscompares++;
                $display("FAIL outputs t=%0t: got %b, expected %b (Clr,LdA,LdB,Sh,Add,Sub,Busy,Done,Step)",
                         $time, act_o, exp_o);
            end
            vectors++;
            if ((Add && Sub) || (Ld_A && Shift_En) || (Clr_A && Shift_En)) begin
                miscompares++;
                $display("FAIL invariant t=%0t: Add=%b Sub=%b Ld_A=%b Clr_A=%b Shift_En=%b, required no overlap",
                         $time, Add, Sub, Ld_A, Clr_A, Shift_En);
            end
            if (Shift_En) sh_cnt++;
            if (Ld_A)     lda_cnt++;
            if (Reset)    sh_cnt = 0;
            if (Done && !done_d) begin
                vectors++;
                if (sh_cnt != W) begin
                    miscompares++;
                    $display("FAIL shift_count: got %0d Shift_En pulses, required %0d", sh_cnt, W);
                end
                sh_cnt = 0;
            end
            done_d = Done;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int guard;
        int hold;
        Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; M = 1'b0;
        @(posedge Clk); #1;
        cycle(0, 0, 1);
        cycle(0, 0, 0);

        // Load B / clear A requests in IDLE.
        repeat (3) cycle(0, 1, 0);
        cycle(0, 0, 0);

        // Run held, all multiplier bits set.
        mb = '1;
        repeat (KDONE + 3) cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);

        // Run pulse with a sparse multiplier: exactly two A loads.
        mb   = 8'b1000_0001;
        base = lda_cnt;
        cycle(1, 0, 0);
        repeat (KDONE) cycle(0, 0, 0);
        vectors++;
        if (lda_cnt - base != 2) begin
            miscompares++;
            $display("FAIL lda_count: got %0d Ld_A pulses, required 2", lda_cnt - base);
        end

        // Reset in SHIFT at Step 3, then a full multiply.
        mb = W'($urandom);
        cycle(1, 0, 0);
        guard = 0;
        while (k != 9 && guard < 40) begin
            cycle(0, 0, 0);
            guard++;
        end
        vectors++;
        if (k != 9) begin
            miscompares++;
            $display("FAIL abort_setup: model offset %0d, required 9", k);
        end
        cycle(0, 0, 1);
        repeat (3) cycle(0, 0, 0);
        mb = W'($urandom);
        cycle(1, 0, 0);
        repeat (KDONE) cycle(0, 0, 0);

        // Run and ClearA_LoadB together: start wins, no Ld_B.
        mb = W'($urandom);
        cycle(1, 1, 0);
        repeat (KDONE) cycle(0, 0, 0);

        // Random multiplies with random Run hold and ClearA_LoadB noise.
        for (int n = 0; n < 8; n++) begin
            mb   = W'($urandom);
            hold = $urandom_range(1, KDONE + 4);
            for (int j = 0; j < hold; j++) cycle(1, 1'($urandom), 0);
            guard = 0;
            while (k != 0 && guard < 4 * KDONE) begin
                cycle(0, 1'($urandom), 0);
                guard++;
            end
            repeat ($urandom_range(0, 3)) cycle(0, 1'($urandom), 0);
        end
        cycle(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
